addon_share_ctrl: RTL
=====================

Name: addon_share_ctrl

Overview:
Scheduler that shares one W-bit adder/subtractor datapath among NUM_REQ requesters. A round-robin arbiter grants one requester per cycle, the controller sets the adder for add or subtract, and the result is registered into a single output stage with a valid/ready handshake. Sits between the requester ports and the shared arithmetic resource in the addon top level.

Parameters:
W, 8, operand/result width in bits
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, requester id width, equal to clog2(NUM_REQ)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_op  in  NUM_REQ  per-requester op: 0 = a+b, 1 = a-b
req_a  in  NUM_REQ*W  packed operand A; requester i at bits [i*W +: W]
req_b  in  NUM_REQ*W  packed operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_sum  out  W  result, modulo 2^W
rsp_carry  out  1  add: carry-out; sub: 1 = no borrow (a >= b unsigned)
rsp_id  out  IDW  index of the requester that owns the result
busy  out  1  high while rsp_valid is high or any req_valid is high

Behaviour:
- Reset: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, rr pointer=0. req_ready is combinational and is 0 while rst=1.
- Accept condition: can_accept = !rsp_valid | rsp_ready. req_ready[i]=1 only for the arbiter winner, and only when can_accept=1.
- Arbitration: round-robin, starting from the pointer. Winner = first i with req_valid[i]=1 in order ptr, ptr+1, ..., wrapping mod NUM_REQ. On accept the pointer becomes (winner+1) mod NUM_REQ. With no accept the pointer holds.
- Datapath: b_eff = op ? ~b : b; cin = op; {carry,sum} = a + b_eff + cin, W+1 bits. Registered on accept.
- Latency: a request accepted in cycle N gives rsp_valid=1 in cycle N+1 with sum, carry and id. Throughput is 1 result per cycle when rsp_ready=1.
- State per cycle:
  - EMPTY (rsp_valid=0) -> FULL on accept.
  - FULL -> FULL on accept while rsp_ready=1: back-to-back, output reloaded.
  - FULL -> EMPTY on rsp_ready=1 with no request.
  - FULL holds with rsp_ready=0: rsp_sum, rsp_carry and rsp_id stay stable, all req_ready=0.
- Requester rules: once asserted, req_valid must hold with stable operands until req_ready. The controller never drops a granted request.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Simultaneous: when the response is consumed and a new request arrives in the same cycle, both happen. No bubble.
- Reset mid-operation: a pending result is discarded, rsp_valid=0 the next cycle, and the pointer returns to 0.
- Widths: no saturation; overflow wraps mod 2^W and is reported only through rsp_carry.

Decomposition:
- Package addon_pkg: W default, NUM_REQ default, OP_ADD=1'b0, OP_SUB=1'b1, IDW derivation function.
- Sub-module addon_rr_arb (NUM_REQ): inputs req vector and advance strobe. Outputs one-hot grant, binary grant index, any-valid. Holds the rotating pointer.
- The adder, output register and handshake logic stay in addon_share_ctrl.

Test Plan:
- Single add: req0 a=8'h0F b=8'h01 op=0, rsp_ready=1 -> req_ready[0] in the same cycle; next cycle rsp_valid=1, sum=8'h10, carry=0, id=0.
- Overflow/sub: req2 a=8'hFF b=8'h02 add -> sum=8'h01, carry=1. Then a=8'h03 b=8'h05 sub -> sum=8'hFE, carry=0.
- Round robin: all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles, one result per cycle, rsp_id matches the order.
- Backpressure: rsp_ready=0 for 3 cycles with a result pending -> rsp_* stable, req_ready=0. rsp_ready=1 -> result consumed and the next request accepted the same cycle.
- Pointer wrap and skip: only req1 and req3 valid, pointer=2 -> grant 3, then 1, then 3.
- Reset mid-operation: rsp_valid=1 with rsp_ready=0, pulse rst one cycle -> rsp_valid=0 and the next grant starts from requester 0.

Source files
------------

// File: rtl/addon_pkg.sv
// rtl/addon_pkg.sv - shared constants, types and helpers for the add/sub sharing controller
package addon_pkg;

   localparam int W_DEF       = 8;
   localparam int NUM_REQ_DEF = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Occupancy of the single result register.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Id width for n requesters; never less than one bit so ports stay legal.
   function automatic int addon_idw(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/addon_rr_arb.sv
// rtl/addon_rr_arb.sv - round-robin arbiter with rotating priority pointer
module addon_rr_arb
   import addon_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDW     = addon_idw(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     gnt_idx,
   output logic               any_valid
);

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;

   // Scan requesters starting at the pointer, wrapping, and pick the first valid one.
   always_comb begin : pick
      int  idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = IDW'(idx);
         end
      end
      if (found) begin
         gnt[gnt_idx] = 1'b1;
      end
      any_valid = found;
   end

   // Pointer moves just past the winner only when the grant is actually taken.
   always_comb begin : next_ptr
      int nxt;
      nxt   = int'(gnt_idx) + 1;
      if (nxt >= NUM_REQ) begin
         nxt = 0;
      end
      ptr_d = ptr_q;
      if (advance && any_valid) begin
         ptr_d = IDW'(nxt);
      end
   end

   // Pointer register; reset restarts priority at requester 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/addon_share_ctrl.sv
// rtl/addon_share_ctrl.sv - shares one add/sub datapath among requesters with a registered result stage
module addon_share_ctrl
   import addon_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDW     = addon_idw(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ-1:0]   req_op,
   input  logic [NUM_REQ*W-1:0] req_a,
   input  logic [NUM_REQ*W-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [W-1:0]         rsp_sum,
   output logic                 rsp_carry,
   output logic [IDW-1:0]       rsp_id,
   output logic                 busy
);

   out_state_e         state_q, state_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               carry_q, carry_d;
   logic [IDW-1:0]     id_q, id_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IDW-1:0]     gnt_idx;
   logic               any_valid;
   logic               can_accept;
   logic               accept;

   logic               sel_op;
   logic [W-1:0]       sel_a;
   logic [W-1:0]       sel_b;
   logic [W-1:0]       b_eff;
   logic [W:0]         full_sum;

   addon_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .advance   (accept),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .any_valid (any_valid)
   );

   // Accept when the output stage is empty or drains this cycle; never while in reset.
   always_comb begin
      can_accept = (state_q == ST_EMPTY) || rsp_ready;
      accept     = can_accept && any_valid && !rst;
      req_ready  = accept ? gnt : '0;
   end

   // Route the winning requester's operands onto the shared adder.
   always_comb begin
      sel_op = OP_ADD;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == gnt_idx) begin
            sel_op = req_op[i];
            sel_a  = req_a[i*W +: W];
            sel_b  = req_b[i*W +: W];
         end
      end
   end

   // Subtract as a + ~b + 1 so carry-out doubles as the "no borrow" flag.
   always_comb begin
      b_eff    = (sel_op == OP_SUB) ? ~sel_b : sel_b;
      full_sum = {1'b0, sel_a} + {1'b0, b_eff} + {{W{1'b0}}, sel_op};
   end

   // Output-stage next state: load on accept, drain on rsp_ready, otherwise hold.
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      id_d    = id_q;
      if (accept) begin
         state_d = ST_FULL;
         sum_d   = full_sum[W-1:0];
         carry_d = full_sum[W];
         id_d    = gnt_idx;
      end else if ((state_q == ST_FULL) && rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // Result register and occupancy state; reset discards any pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         sum_q   <= '0;
         carry_q <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         id_q    <= id_d;
      end
   end

   // Response outputs come straight from flops.
   always_comb begin
      rsp_valid = (state_q == ST_FULL);
      rsp_sum   = sum_q;
      rsp_carry = carry_q;
      rsp_id    = id_q;
      busy      = rsp_valid || (|req_valid);
   end

endmodule
